// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: 2-FF synchroniser, oversampling bit FSM and a
// first-word-fall-through receive FIFO with sticky overrun/framing flags.
module uart_rx_fifo #(
  parameter int CLOCK_FREQUENCY = 500_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          CLK,
  input  logic                          NRST,
  input  logic                          UART_RX_DSER,
  output logic [7:0]                    RX_DATA,
  output logic                          RX_VALID,
  input  logic                          RX_READY,
  output logic [$clog2(FIFO_DEPTH):0]   RX_COUNT,
  output logic                          OVERRUN,
  output logic                          FRAME_ERR,
  input  logic                          ERR_CLR
);

  localparam int CPB = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  if (CPB < 8) begin : g_cpb_check
    $error("uart_rx_fifo: CLOCK_FREQUENCY/BAUD_RATE must be at least 8");
  end

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic [1:0]    r_sync;
  logic          w_rxs;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_tick;
  logic          w_cnt_load;
  logic [CW-1:0] w_cnt_val;
  logic [2:0]    r_idx;
  logic          w_idx_clr;
  logic          w_shift_en;
  logic [7:0]    r_shift;
  logic          w_push_req;
  logic          w_ferr_set;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovr_set;
  logic          r_overrun;
  logic          r_frame_err;

  // Two-stage synchroniser; resets to the idle (high) line level.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], UART_RX_DSER};
    end
  end

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_cnt == {CW{1'b0}});

  // FSM state register.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = C_FULL;
    w_idx_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_push_req  = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_cnt_load  = 1'b1;
          w_cnt_val   = C_HALF;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!w_rxs) begin
            w_state_nxt = S_DATA;
            w_cnt_load  = 1'b1;
            w_idx_clr   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          w_cnt_load = 1'b1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_rxs) begin
            w_push_req  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bit-period down-counter, bit index and LSB-first shift register.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_cnt   <= {CW{1'b0}};
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      if (w_cnt_load) begin
        r_cnt <= w_cnt_val;
      end else if (!w_tick) begin
        r_cnt <= r_cnt - C_ONE;
      end
      if (w_idx_clr) begin
        r_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_shift[r_idx] <= w_rxs;
        r_idx          <= r_idx + 3'd1;
      end
    end
  end

  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop     = RX_READY && !w_empty;
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_ovr_set = w_push_req && w_full && !w_pop;

  // Storage is deliberately left unreset; the output mask hides stale data.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= r_shift;
    end
  end

  // FIFO pointers with wrap bit.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_wr <= {(AW+1){1'b0}};
      r_rd <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr <= r_wr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd <= r_rd + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Sticky error flags; a new error wins over a coincident clear.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (ERR_CLR) begin
        r_overrun <= 1'b0;
      end
      if (w_ferr_set) begin
        r_frame_err <= 1'b1;
      end else if (ERR_CLR) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign RX_VALID  = !w_empty;
  assign RX_DATA   = w_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
  assign RX_COUNT  = r_wr - r_rd;
  assign OVERRUN   = r_overrun;
  assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo at CPB=10 with a 4-entry FIFO.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB = 10;

  logic       CLK;
  logic       NRST;
  logic       UART_RX_DSER;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic [2:0] RX_COUNT;
  logic       OVERRUN;
  logic       FRAME_ERR;
  logic       ERR_CLR;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;

  uart_rx_fifo #(
    .CLOCK_FREQUENCY(1_000_000),
    .BAUD_RATE      (100_000),
    .FIFO_DEPTH     (4)
  ) dut (
    .CLK         (CLK),
    .NRST        (NRST),
    .UART_RX_DSER(UART_RX_DSER),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .RX_READY    (RX_READY),
    .RX_COUNT    (RX_COUNT),
    .OVERRUN     (OVERRUN),
    .FRAME_ERR   (FRAME_ERR),
    .ERR_CLR     (ERR_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives one 8N1 frame; a bad stop bit keeps the line low 30 cycles (break).
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    UART_RX_DSER = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_RX_DSER = b[i];
      wait_cyc(CPB);
    end
    if (stop_ok) begin
      UART_RX_DSER = 1'b1;
      wait_cyc(CPB);
    end else begin
      UART_RX_DSER = 1'b0;
      wait_cyc(30);
      UART_RX_DSER = 1'b1;
      wait_cyc(CPB);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, RX_VALID}, 32'd1);
    check({tag, "_data"}, {24'd0, RX_DATA}, {24'd0, e});
    RX_READY = 1'b1;
    wait_cyc(1);
    RX_READY = 1'b0;
  endtask

  // Streaming monitor: every handshake must match the scoreboard head.
  always @(negedge CLK) begin
    if (mon_en && RX_VALID && RX_READY) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL stream_extra: observed byte 0x%0h expected none", RX_DATA);
      end
      if (exp_q.size() != 0) begin
        check("stream_data", {24'd0, RX_DATA}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    NRST         = 1'b0;
    UART_RX_DSER = 1'b1;
    RX_READY     = 1'b0;
    ERR_CLR      = 1'b0;
    #23;
    check("rst_valid", {31'd0, RX_VALID}, 32'd0);
    check("rst_count", {29'd0, RX_COUNT}, 32'd0);
    check("rst_data", {24'd0, RX_DATA}, 32'h00);
    check("rst_ovr", {31'd0, OVERRUN}, 32'd0);
    check("rst_ferr", {31'd0, FRAME_ERR}, 32'd0);
    wait_cyc(1);
    NRST = 1'b1;
    wait_cyc(5);

    // Single byte with exact push latency.
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (97) @(posedge CLK);
        #1;
        check("lat_valid_early", {31'd0, RX_VALID}, 32'd0);
        @(posedge CLK);
        #1;
        check("lat_valid", {31'd0, RX_VALID}, 32'd1);
        check("lat_count", {29'd0, RX_COUNT}, 32'd1);
      end
    join
    check("t1_count", {29'd0, RX_COUNT}, 32'd1);
    pop_check("t1_pop");
    check("t1_valid_after", {31'd0, RX_VALID}, 32'd0);
    check("t1_count_after", {29'd0, RX_COUNT}, 32'd0);
    check("t1_data_masked", {24'd0, RX_DATA}, 32'h00);

    // Glitch on the line is rejected silently.
    UART_RX_DSER = 1'b0;
    wait_cyc(3);
    UART_RX_DSER = 1'b1;
    wait_cyc(20);
    check("t2_count", {29'd0, RX_COUNT}, 32'd0);
    check("t2_ferr", {31'd0, FRAME_ERR}, 32'd0);
    check("t2_ovr", {31'd0, OVERRUN}, 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    pop_check("t2_pop");

    // Framing error followed by a good byte, then clear.
    send_byte(8'h55, 1'b0);
    check("t3_ferr", {31'd0, FRAME_ERR}, 32'd1);
    check("t3_count", {29'd0, RX_COUNT}, 32'd0);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    pop_check("t3_pop");
    check("t3_ferr_held", {31'd0, FRAME_ERR}, 32'd1);
    ERR_CLR = 1'b1;
    wait_cyc(1);
    ERR_CLR = 1'b0;
    check("t3_ferr_clr", {31'd0, FRAME_ERR}, 32'd0);

    // Overrun with a 4-deep FIFO and no consumer.
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      send_byte(8'(v), 1'b1);
    end
    check("t4_count", {29'd0, RX_COUNT}, 32'd4);
    check("t4_ovr", {31'd0, OVERRUN}, 32'd1);
    ERR_CLR = 1'b1;
    wait_cyc(1);
    ERR_CLR = 1'b0;
    check("t4_ovr_clr", {31'd0, OVERRUN}, 32'd0);
    fork
      send_byte(8'h06, 1'b1);
      begin
        repeat (97) @(posedge CLK);
        #1;
        ERR_CLR = 1'b1;
        @(posedge CLK);
        #1;
        ERR_CLR = 1'b0;
      end
    join
    check("t4_ovr_prio", {31'd0, OVERRUN}, 32'd1);
    check("t4_count2", {29'd0, RX_COUNT}, 32'd4);
    for (int i = 0; i < 4; i++) pop_check("t4_pop");
    check("t4_empty", {31'd0, RX_VALID}, 32'd0);

    // Full FIFO with a pop in the push cycle.
    ERR_CLR = 1'b1;
    wait_cyc(1);
    ERR_CLR = 1'b0;
    check("t5_ovr_clr", {31'd0, OVERRUN}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i * 17));
      send_byte(8'(i * 17), 1'b1);
    end
    check("t5_full", {29'd0, RX_COUNT}, 32'd4);
    exp_q.push_back(8'h66);
    fork
      send_byte(8'h66, 1'b1);
      begin
        repeat (97) @(posedge CLK);
        #1;
        check("t5_head", {24'd0, RX_DATA}, {24'd0, exp_q.pop_front()});
        RX_READY = 1'b1;
        @(posedge CLK);
        #1;
        RX_READY = 1'b0;
      end
    join
    check("t5_ovr", {31'd0, OVERRUN}, 32'd0);
    check("t5_count", {29'd0, RX_COUNT}, 32'd4);
    for (int i = 0; i < 4; i++) pop_check("t5_pop");
    check("t5_empty", {31'd0, RX_VALID}, 32'd0);

    // Stream 10 bytes with the consumer always ready (pointer wrap).
    RX_READY = 1'b1;
    mon_en   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'(8'h5A + i * 8'h13));
      send_byte(8'(8'h5A + i * 8'h13), 1'b1);
    end
    mon_en   = 1'b0;
    RX_READY = 1'b0;
    check("t5_stream_left", exp_q.size(), 32'd0);
    check("t5_stream_count", {29'd0, RX_COUNT}, 32'd0);
    check("t5_stream_ovr", {31'd0, OVERRUN}, 32'd0);

    // Reset in the middle of data bit 4.
    exp_q.push_back(8'h99);
    send_byte(8'h99, 1'b1);
    send_byte(8'h00, 1'b0);
    check("t6_pre_valid", {31'd0, RX_VALID}, 32'd1);
    check("t6_pre_ferr", {31'd0, FRAME_ERR}, 32'd1);
    UART_RX_DSER = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      UART_RX_DSER = (8'hC3 >> i) & 8'h01;
      wait_cyc(CPB);
    end
    UART_RX_DSER = 1'b0;
    wait_cyc(CPB / 2);
    NRST = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, RX_VALID}, 32'd0);
    check("t6_rst_count", {29'd0, RX_COUNT}, 32'd0);
    check("t6_rst_data", {24'd0, RX_DATA}, 32'h00);
    check("t6_rst_ferr", {31'd0, FRAME_ERR}, 32'd0);
    check("t6_rst_ovr", {31'd0, OVERRUN}, 32'd0);
    exp_q.delete();
    UART_RX_DSER = 1'b1;
    wait_cyc(3);
    NRST = 1'b1;
    wait_cyc(3);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    check("t6_count", {29'd0, RX_COUNT}, 32'd1);
    pop_check("t6_pop");
    check("t6_empty", {29'd0, RX_COUNT}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receive path for the MCU's serial peripheral: oversamples the asynchronous 8N1 line `UART_RX_DSER`, deserialises bytes LSB-first, and buffers them in a small FIFO. Received bytes go to the memory-mapped UART register block through a valid/ready handshake. It sits directly downstream of the MCU pin `UART_RX_DSER`, which the system bench loops back from `UART_TX_DSER`. Framing and overrun errors are reported as sticky flags.

## Interface
- `CLOCK_FREQUENCY`, 500_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in baud.
  - CPB = `CLOCK_FREQUENCY`/`BAUD_RATE`, integer-truncated.
  - CPB must be ≥ 8; elaboration fails otherwise.
- `FIFO_DEPTH`, 16: receive FIFO entries; power of two, ≥ 2.

- `CLK` in 1: system clock, rising edge.
- `NRST` in 1: reset, asynchronous, active-low.
- `UART_RX_DSER` in 1: serial line, idle high, asynchronous to `CLK`.
- `RX_DATA` out 8: byte at FIFO head; valid when `RX_VALID`=1.
- `RX_VALID` out 1: FIFO not empty.
- `RX_READY` in 1: consumer pops the head when `RX_VALID` && `RX_READY`.
- `RX_COUNT` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `OVERRUN` out 1: sticky; a byte was dropped because the FIFO was full.
- `FRAME_ERR` out 1: sticky; a stop bit was sampled low.
- `ERR_CLR` in 1: single-cycle pulse that clears both sticky flags.

## Operation
- **Input synchroniser:** 2-FF on `UART_RX_DSER`, both stages reset to 1; call its output `rxs`. All decisions use `rxs`.
- **Bit counter:** down-counter; "tick" = counter at 0.
- **State machine** (states IDLE, START, DATA, STOP, WAIT_HIGH):
  - IDLE: when `rxs`=0, load counter with CPB/2−1 and go to START.
  - START: on tick, sample `rxs`.
    - 0: load CPB−1, bit index 0, go to DATA.
    - 1: glitch; return to IDLE, no flag.
  - DATA: on tick, shift `rxs` into bit[index], reload CPB−1. After index 7, go to STOP.
  - STOP: on tick, sample `rxs`.
    - 1: push the byte and go to IDLE.
    - 0: set `FRAME_ERR`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. This prevents a break condition from re-triggering reception.
- **FIFO:** read/write pointers with an extra wrap bit; first-word-fall-through (`RX_DATA` = mem[rd_ptr]).
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped, `OVERRUN` is set, and FIFO contents are unchanged.
  - A pop while empty is ignored; pointers do not move.
  - A simultaneous push and pop leaves `RX_COUNT` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH` and flip the wrap bit.
- **Sticky flags:** set has priority over `ERR_CLR` in the same cycle.
- **Reset values:**
  - FSM in IDLE; FIFO empty (`RX_VALID`=0, `RX_COUNT`=0); `RX_DATA`=0x00 (memory not reset, but output masked to 0 when empty).
  - `OVERRUN`=0, `FRAME_ERR`=0; synchroniser stages = 1.
- **Reset mid-frame:** the partial byte is lost, the FIFO is emptied, and reception restarts cleanly on the next start bit.

## Timing
- Synchroniser latency: a line change is visible on `rxs` 2 rising edges later.
- Let T0 be the first IDLE cycle with `rxs`=0. Samples occur at:
  - start bit: T0+CPB/2;
  - data bit i: T0+CPB/2+(i+1)·CPB;
  - stop bit: T0+CPB/2+9·CPB.
- The push is registered at the stop-sample edge. `RX_VALID`/`RX_COUNT` update on the following cycle (T0+CPB/2+9·CPB+1).
- A pop is registered: `RX_COUNT` and the head update on the next cycle.
- `OVERRUN` and `FRAME_ERR` assert the cycle after the stop sample.
- Back-to-back frames: the FSM is in IDLE 1 cycle after the stop sample, so a start edge arriving half a bit later is caught. Up to ±4% baud mismatch is tolerated.

## Test plan
1. **Single byte:** CPB=10 (1 MHz/100 kbaud), send 0xA5 → `RX_DATA`=0xA5, `RX_VALID`=1 at T0+96, `RX_COUNT`=1; pop → `RX_VALID`=0.
2. **Glitch:** line low for 3 cycles, then high → no push, `RX_COUNT`=0, flags 0; a following 0x3C is received correctly.
3. **Framing error:** 0x55 with stop bit 0, line held low 30 cycles then high → `FRAME_ERR`=1, no push. Next 0x0F is received; `ERR_CLR` → `FRAME_ERR`=0.
4. **Overrun:** `FIFO_DEPTH`=4, `RX_READY`=0, send 0x01..0x05 → `RX_COUNT`=4, pops yield 0x01..0x04, `OVERRUN`=1. `ERR_CLR` coincident with a new overrun leaves `OVERRUN`=1.
5. **Full with simultaneous pop:** FIFO full, pop in the push cycle → byte accepted, `OVERRUN`=0, `RX_COUNT` stays 4. Pointer wrap is verified over 10 bytes streamed with `RX_READY`=1.
6. **Reset mid-frame:** deassert `NRST` during data bit 4 → all outputs return to reset values immediately. After release, 0xC3 is received intact.
